riscv_dmem_hs: RTL and testbench
================================

# riscv_dmem_hs

Parametrised data memory with a valid/ready request/response handshake and configurable access latency. It succeeds the single-cycle data memory: it sits between the CPU load/store unit and the data RAM in multi-cycle and pipelined cores, and models wait-state memory. It also flags misaligned and out-of-range accesses instead of silently aliasing them. One outstanding request at a time.

## Interface
- XLEN, 32: data and address width; must be 32 or 64.
- DEPTH_WORDS, 1024: number of XLEN-wide words; power of two.
- RD_LATENCY, 2: cycles from read acceptance to response valid; legal range 1..8.
- WR_LATENCY, 1: cycles from write acceptance to response valid; legal range 1..8.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request ready.
- i_req_wr_en  in  1  1 = write, 0 = read.
- i_req_addr  in  XLEN  byte address.
- i_req_byte_sel  in  XLEN/8  write byte enables; bit k enables byte k (bits 8k+7:8k).
- i_req_wr_data  in  XLEN  write data.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response accepted by consumer.
- o_rsp_rd_data  out  XLEN  read data; 0 for writes and errored accesses.
- o_rsp_err  out  1  access error: misaligned or out of range.

## Operation
- FSM states:
  - IDLE: o_req_ready=1. Accept on i_req_valid && o_req_ready, capturing addr, wr_en, byte_sel and wr_data. Load the counter with the latency (RD_LATENCY or WR_LATENCY) minus 1. Go to WAIT, or to RESP directly if the loaded value is 0.
  - WAIT: decrement the counter each cycle; at 0, go to RESP.
  - RESP: o_rsp_valid=1; hold until i_rsp_ready=1, then go to IDLE.
- o_req_ready is 1 only in IDLE and when i_rst=0. Request inputs are ignored outside IDLE.
- Word index is addr[log2(DEPTH_WORDS)+log2(XLEN/8)-1 : log2(XLEN/8)].
- Misaligned access: addr[log2(XLEN/8)-1:0] != 0.
- Out-of-range access: addr >= DEPTH_WORDS*XLEN/8.
- Errored access: no array write, o_rsp_rd_data=0, o_rsp_err=1. Latency is the normal RD_LATENCY or WR_LATENCY.
- Write commit: on the clock edge that enters RESP, only the selected bytes are updated. A write with byte_sel=0 modifies nothing and returns err=0.
- Read: the full word is sampled from the array on the edge entering RESP. byte_sel is ignored on reads.
- o_rsp_rd_data and o_rsp_err are registered. They stay stable throughout RESP regardless of i_rsp_ready.
- Array contents are not cleared by reset and are undefined before the first write.

## Timing
- Reset values: FSM=IDLE, counter=0, o_rsp_valid=0, o_rsp_rd_data=0, o_rsp_err=0. o_req_ready=0 while i_rst=1 and 1 in the first cycle after release.
- Acceptance at edge N: o_rsp_valid rises in the cycle after edge N+L-1, where L is the applicable latency. L=1 gives a response valid in the cycle directly after acceptance.
- Response handshake at edge M: o_rsp_valid=0 and o_req_ready=1 in the following cycle. Back-to-back request period is L+1 cycles when i_rsp_ready is held at 1.
- Backpressure: RESP may be held for any number of cycles. Data and err stay stable and no new request is accepted.
- Reset mid-operation (WAIT or RESP): abandon the transaction and return to IDLE. No response is issued. A write still in WAIT is not committed; a write already in RESP has been committed.
- i_req_valid asserted during reset is not accepted.

## Test plan
- Write then read, RD_LATENCY=2, WR_LATENCY=1: write 0xDEADBEEF to 0x10 with byte_sel=0xF -> rsp_valid 1 cycle after acceptance, err=0. Read 0x10 -> rsp_valid 2 cycles after acceptance, rd_data=0xDEADBEEF.
- Partial write: write 0x11223344 to 0x10 with byte_sel=0b0101 over 0xDEADBEEF -> read 0x10 returns 0xDE22BE44.
- Errors: read 0x12 -> err=1, rd_data=0. Write 0x00001000 with DEPTH_WORDS=1024 -> err=1, and words 0x0 and 0x1000 modulo aliasing are unchanged.
- Backpressure: hold i_rsp_ready=0 for 3 cycles in RESP while i_req_valid=1 -> o_req_ready=0, rd_data and err stable, exactly one response. The next request is accepted 1 cycle after the handshake.
- Reset mid-operation: accept a write of 0xAAAAAAAA to 0x20 with WR_LATENCY=4 and assert i_rst in WAIT -> no rsp_valid. A later read of 0x20 returns the prior value, and o_req_ready=1 the cycle after release.
- Latency sweep: RD_LATENCY in {1,3,8} -> rsp_valid exactly L cycles after acceptance on every read.

Source files
------------

// File: rtl/riscv_dmem_hs.sv
// Data memory with a valid/ready request/response handshake, configurable wait states,
// and misaligned/out-of-range error reporting. One transaction in flight at a time.
module riscv_dmem_hs #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 2,
  parameter int WR_LATENCY  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr_en,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN/8-1:0] i_req_byte_sel,
  input  logic [XLEN-1:0]   i_req_wr_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [XLEN-1:0]   o_rsp_rd_data,
  output logic              o_rsp_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFF  = $clog2(NB);
  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam int AW   = IDXW + OFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] RD_LM1 = 3'(RD_LATENCY - 1);
  localparam logic [2:0] WR_LM1 = 3'(WR_LATENCY - 1);

  logic [1:0]      state;
  logic [2:0]      cnt;
  logic            wr_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [NB-1:0]   bsel_q;
  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            accept;
  logic [2:0]      lat_m1;
  logic            enter_resp;
  logic            cur_wr;
  logic [XLEN-1:0] cur_addr;
  logic [XLEN-1:0] cur_wdata;
  logic [NB-1:0]   cur_bsel;
  logic            cur_err;
  logic [IDXW-1:0] cur_idx;

  assign o_req_ready = (state == ST_IDLE) && !i_rst;
  assign o_rsp_valid = (state == ST_RESP);
  assign accept      = i_req_valid && o_req_ready;
  assign lat_m1      = i_req_wr_en ? WR_LM1 : RD_LM1;

  // With a one-cycle latency the access completes on the acceptance edge itself,
  // so the live request inputs are used instead of the captured copy.
  always_comb begin
    cur_wr    = wr_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_bsel  = bsel_q;
    if (state == ST_IDLE) begin
      cur_wr    = i_req_wr_en;
      cur_addr  = i_req_addr;
      cur_wdata = i_req_wr_data;
      cur_bsel  = i_req_byte_sel;
    end
  end

  assign cur_err    = (|cur_addr[OFF-1:0]) || (|cur_addr[XLEN-1:AW]);
  assign cur_idx    = cur_addr[AW-1:OFF];
  assign enter_resp = !i_rst && ((accept && lat_m1 == 3'd0) ||
                                 (state == ST_WAIT && cnt == 3'd1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      cnt           <= 3'd0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bsel_q        <= '0;
      o_rsp_rd_data <= '0;
      o_rsp_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wr_q    <= i_req_wr_en;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wr_data;
            bsel_q  <= i_req_byte_sel;
            cnt     <= lat_m1;
            state   <= (lat_m1 == 3'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 3'd1) begin
            cnt   <= 3'd0;
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (enter_resp) begin
        o_rsp_err     <= cur_err;
        o_rsp_rd_data <= (cur_err || cur_wr) ? '0 : mem[cur_idx];
      end
    end
  end

  // Array has no reset; only error-free writes commit, and only their selected bytes.
  always_ff @(posedge i_clk) begin
    if (enter_resp && cur_wr && !cur_err) begin
      for (int b = 0; b < NB; b++) begin
        if (cur_bsel[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_hs.sv
// Bench for riscv_dmem_hs: four instances with different latencies, directed requests,
// and a negedge monitor checking latency, stability and response data against a queue.
module tb_riscv_dmem_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       rst       = 4'hF;
  logic [3:0]       req_valid = 4'h0;
  logic [3:0]       rsp_ready = 4'hF;
  logic [3:0]       req_ready;
  logic [3:0]       rsp_valid;
  logic [3:0]       rsp_err;
  logic [3:0][31:0] rd_data;
  logic             wr_en = 1'b0;
  logic [31:0]      addr  = '0;
  logic [31:0]      wdata = '0;
  logic [3:0]       bsel  = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [34:0] exp_q[$];
  int          acc_q[$];
  int          lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  riscv_dmem_hs #(.XLEN(32), .DEPTH_WORDS(1024), .RD_LATENCY(2), .WR_LATENCY(1)) u0 (
    .i_clk(clk), .i_rst(rst[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_wr_en(wr_en), .i_req_addr(addr), .i_req_byte_sel(bsel), .i_req_wr_data(wdata),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_rd_data(rd_data[0]),
    .o_rsp_err(rsp_err[0]));

  riscv_dmem_hs #(.XLEN(32), .DEPTH_WORDS(1024), .RD_LATENCY(1), .WR_LATENCY(4)) u1 (
    .i_clk(clk), .i_rst(rst[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_wr_en(wr_en), .i_req_addr(addr), .i_req_byte_sel(bsel), .i_req_wr_data(wdata),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_rd_data(rd_data[1]),
    .o_rsp_err(rsp_err[1]));

  riscv_dmem_hs #(.XLEN(32), .DEPTH_WORDS(1024), .RD_LATENCY(3), .WR_LATENCY(4)) u2 (
    .i_clk(clk), .i_rst(rst[2]), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
    .i_req_wr_en(wr_en), .i_req_addr(addr), .i_req_byte_sel(bsel), .i_req_wr_data(wdata),
    .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]), .o_rsp_rd_data(rd_data[2]),
    .o_rsp_err(rsp_err[2]));

  riscv_dmem_hs #(.XLEN(32), .DEPTH_WORDS(1024), .RD_LATENCY(8), .WR_LATENCY(1)) u3 (
    .i_clk(clk), .i_rst(rst[3]), .i_req_valid(req_valid[3]), .o_req_ready(req_ready[3]),
    .i_req_wr_en(wr_en), .i_req_addr(addr), .i_req_byte_sel(bsel), .i_req_wr_data(wdata),
    .o_rsp_valid(rsp_valid[3]), .i_rsp_ready(rsp_ready[3]), .o_rsp_rd_data(rd_data[3]),
    .o_rsp_err(rsp_err[3]));

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: samples on the falling edge, between the bench's drive points.
  logic [3:0]  prev_v  = 4'h0;
  logic [3:0]  hs_prev = 4'h0;
  logic [31:0] held_d [4];
  logic        held_e [4];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (hs_prev[k]) chk("idle_after_handshake", {rsp_valid[k], req_ready[k]}, 2'b01);
      if (rsp_valid[k]) begin
        chk("no_ready_in_resp", req_ready[k], 1'b0);
        if (!prev_v[k]) begin
          if (acc_q.size() == 0) begin
            chk("unexpected_rsp_valid", k, 99);
          end else begin
            chk("latency", cyc - acc_q.pop_front() + 1, lat_q.pop_front());
          end
          held_d[k] = rd_data[k];
          held_e[k] = rsp_err[k];
        end else begin
          chk("rsp_stable", {rsp_err[k], rd_data[k]}, {held_e[k], held_d[k]});
        end
        if (rsp_ready[k]) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", k, 99);
          else chk("rsp", {2'(k), rsp_err[k], rd_data[k]}, exp_q.pop_front());
        end
      end
      hs_prev[k] = rsp_valid[k] && rsp_ready[k];
      prev_v[k]  = rsp_valid[k];
    end
  end

  task automatic send(input int k, input logic w, input logic [31:0] a, input logic [3:0] bs,
                      input logic [31:0] wd, input logic e_err, input logic [31:0] e_data,
                      input int lat, input bit push);
    bit ok = 1'b0;
    @(posedge clk); #1;
    wr_en = w; addr = a; bsel = bs; wdata = wd;
    req_valid[k] = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[k]) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else if (push) begin
      acc_q.push_back(cyc + 1);
      lat_q.push_back(lat);
      exp_q.push_back({2'(k), e_err, e_data});
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic drain();
    bool_wait: for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && acc_q.size() == 0) break;
    end
    if (exp_q.size() != 0 || acc_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // Reset, with requests asserted that must not be accepted.
    req_valid = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 4'h0);
    chk("reset_rsp_valid", rsp_valid, 4'h0);
    chk("reset_rsp_err", rsp_err, 4'h0);
    chk("reset_rd_data0", rd_data[0], 0);
    chk("reset_rd_data3", rd_data[3], 0);
    @(posedge clk); #1;
    rst = 4'h0;
    req_valid = 4'h0;
    @(negedge clk);
    chk("ready_after_release", req_ready, 4'hF);
    chk("no_valid_after_release", rsp_valid, 4'h0);

    // Instance 0: RD=2, WR=1.
    send(0, 1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1, 1);
    send(0, 1'b0, 32'h10,   4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1);
    send(0, 1'b1, 32'h10,   4'h5, 32'h11223344, 1'b0, 32'h0,        1, 1);
    send(0, 1'b0, 32'h10,   4'h0, 32'h0,        1'b0, 32'hDE22BE44, 2, 1);
    send(0, 1'b1, 32'h10,   4'h0, 32'hFFFFFFFF, 1'b0, 32'h0,        1, 1);
    send(0, 1'b0, 32'h10,   4'hF, 32'h0,        1'b0, 32'hDE22BE44, 2, 1);
    send(0, 1'b0, 32'h12,   4'hF, 32'h0,        1'b1, 32'h0,        2, 1);
    send(0, 1'b1, 32'h0,    4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        1, 1);
    send(0, 1'b1, 32'h1000, 4'hF, 32'h12345678, 1'b1, 32'h0,        1, 1);
    send(0, 1'b1, 32'h3,    4'hF, 32'h87654321, 1'b1, 32'h0,        1, 1);
    send(0, 1'b0, 32'h0,    4'hF, 32'h0,        1'b0, 32'hCAFEF00D, 2, 1);
    send(0, 1'b0, 32'h1000, 4'hF, 32'h0,        1'b1, 32'h0,        2, 1);
    send(0, 1'b1, 32'hFFC,  4'hF, 32'hA5A5A5A5, 1'b0, 32'h0,        1, 1);
    send(0, 1'b0, 32'hFFC,  4'hF, 32'h0,        1'b0, 32'hA5A5A5A5, 2, 1);
    drain();

    // Backpressure: response held three cycles while the next request waits.
    rsp_ready[0] = 1'b0;
    send(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDE22BE44, 2, 1);
    fork
      send(0, 1'b1, 32'h14, 4'hF, 32'h55AA55AA, 1'b0, 32'h0, 1, 1);
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (rsp_valid[0]) seen = 1'b1;
        end
        if (!seen) chk("bp_valid_timeout", 0, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
      end
    join
    send(0, 1'b0, 32'h14, 4'hF, 32'h0, 1'b0, 32'h55AA55AA, 2, 1);
    drain();

    // Instance 1: RD=1, WR=4, including a reset while a write waits.
    send(1, 1'b1, 32'h20, 4'hF, 32'h12345678, 1'b0, 32'h0,        4, 1);
    send(1, 1'b0, 32'h20, 4'hF, 32'h0,        1'b0, 32'h12345678, 1, 1);
    drain();
    send(1, 1'b1, 32'h20, 4'hF, 32'hAAAAAAAA, 1'b0, 32'h0, 4, 0);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("ready_in_mid_reset", req_ready[1], 1'b0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_reset", req_ready[1], 1'b1);
    repeat (6) @(negedge clk);
    send(1, 1'b0, 32'h20, 4'hF, 32'h0,        1'b0, 32'h12345678, 1, 1);
    send(1, 1'b1, 32'h24, 4'hF, 32'h0BADBEEF, 1'b0, 32'h0,        4, 1);
    send(1, 1'b0, 32'h24, 4'hF, 32'h0,        1'b0, 32'h0BADBEEF, 1, 1);
    drain();

    // Instance 2: RD=3, WR=4.
    send(2, 1'b1, 32'h40, 4'hF, 32'h13579BDF, 1'b0, 32'h0,        4, 1);
    send(2, 1'b0, 32'h40, 4'hF, 32'h0,        1'b0, 32'h13579BDF, 3, 1);
    send(2, 1'b0, 32'h40, 4'h1, 32'h0,        1'b0, 32'h13579BDF, 3, 1);
    send(2, 1'b0, 32'h41, 4'hF, 32'h0,        1'b1, 32'h0,        3, 1);
    drain();

    // Instance 3: RD=8, WR=1.
    send(3, 1'b1, 32'h80,   4'hF, 32'h2468ACE0, 1'b0, 32'h0,        1, 1);
    send(3, 1'b0, 32'h80,   4'hF, 32'h0,        1'b0, 32'h2468ACE0, 8, 1);
    send(3, 1'b0, 32'h80,   4'hF, 32'h0,        1'b0, 32'h2468ACE0, 8, 1);
    send(3, 1'b0, 32'h2000, 4'hF, 32'h0,        1'b1, 32'h0,        8, 1);
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
